// File: rtl/br_resolve.sv
// Branch resolver: compares EX results against the frontend prediction and issues a
// registered redirect with epoch tagging. Optional perf counters: BR_RESOLVE_PERF_EN.
package br_resolve_pkg;
  typedef struct packed {
    logic        flush;
    logic [29:0] br_target;
  } bpu_update_t;
endpackage

module br_resolve
  import br_resolve_pkg::*;
#(
  parameter int unsigned EPOCH_W     = 2,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic [EPOCH_W-1:0] ex_epoch_i,
  input  logic [31:0]        ex_pc_i,
  input  logic               ex_is_br_i,
  input  logic               ex_taken_i,
  input  logic [31:0]        ex_target_i,
  input  logic               pred_taken_i,
  input  logic [31:0]        pred_npc_i,
  input  logic               exc_flush_i,
  input  logic [31:0]        exc_target_i,
  output bpu_update_t        update_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic [31:0]        br_cnt_o,
  output logic [31:0]        mispred_cnt_o
);

  localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES);

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e             state_q;
  logic [3:0]         hold_q;
  logic [EPOCH_W-1:0] epoch_q;
  bpu_update_t        update_q;

  logic        xfer, cur_epoch, br_wrong, mispred, trigger;
  logic [31:0] actual_npc, flush_target;
  logic        unused_bits;

  assign ex_ready_o = (state_q == StRun);
  assign update_o   = update_q;
  assign epoch_o    = epoch_q;

  always_comb begin
    xfer         = ex_valid_i & ex_ready_o;
    cur_epoch    = (ex_epoch_i == epoch_q);
    actual_npc   = (ex_is_br_i & ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
    br_wrong     = (ex_taken_i != pred_taken_i) | (ex_taken_i & (ex_target_i != pred_npc_i));
    // A non-branch the frontend predicted taken is a false-predicted branch.
    mispred      = xfer & cur_epoch & (ex_is_br_i ? br_wrong : pred_taken_i);
    trigger      = exc_flush_i | mispred;
    flush_target = exc_flush_i ? exc_target_i : actual_npc;
  end

  // Low target bits are dropped; the frontend works on word addresses.
  assign unused_bits = ^flush_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StRun;
      hold_q             <= 4'd0;
      epoch_q            <= '0;
      update_q.flush     <= 1'b0;
      update_q.br_target <= 30'd0;
    end else begin
      update_q.flush <= trigger;
      if (trigger) begin
        update_q.br_target <= flush_target[31:2];
        epoch_q            <= epoch_q + EPOCH_W'(1);
        hold_q             <= HoldLoad;
        state_q            <= StHold;
      end else if (state_q == StHold) begin
        hold_q <= hold_q - 4'd1;
        if (hold_q == 4'd1) state_q <= StRun;
      end
    end
  end

`ifdef BR_RESOLVE_PERF_EN
  logic [31:0] br_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q      <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      if (xfer & cur_epoch & ex_is_br_i) br_cnt_q <= br_cnt_q + 32'd1;
      // Exceptions win the redirect, so they do not count as mispredict flushes.
      if (mispred & ~exc_flush_i) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
`else
  assign br_cnt_o      = 32'd0;
  assign mispred_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: directed scenarios plus random traffic
// against a cycle-indexed behavioural model.
module tb_br_resolve;
  import br_resolve_pkg::*;

  localparam int EW   = 2;
  localparam int HOLD = 2;

  logic          clk, rst_n;
  logic          ex_valid_i, ex_ready_o, ex_is_br_i, ex_taken_i, pred_taken_i, exc_flush_i;
  logic [EW-1:0] ex_epoch_i, epoch_o;
  logic [31:0]   ex_pc_i, ex_target_i, pred_npc_i, exc_target_i, br_cnt_o, mispred_cnt_o;
  bpu_update_t   update_o;

  br_resolve #(.EPOCH_W(EW), .HOLD_CYCLES(HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_epoch_i   (ex_epoch_i),
    .ex_pc_i      (ex_pc_i),
    .ex_is_br_i   (ex_is_br_i),
    .ex_taken_i   (ex_taken_i),
    .ex_target_i  (ex_target_i),
    .pred_taken_i (pred_taken_i),
    .pred_npc_i   (pred_npc_i),
    .exc_flush_i  (exc_flush_i),
    .exc_target_i (exc_target_i),
    .update_o     (update_o),
    .epoch_o      (epoch_o),
    .br_cnt_o     (br_cnt_o),
    .mispred_cnt_o(mispred_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: epoch as an integer, ready as "first cycle index at which ready returns".
  int          m_epoch, m_ready_from, m_cyc;
  bit          m_flush;
  logic [29:0] m_tgt;
  int unsigned m_br, m_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_epoch = 0; m_ready_from = 0; m_flush = 0; m_tgt = '0; m_br = 0; m_mis = 0;
  endtask

  task automatic drive(input bit v, input int ep, input logic [31:0] pc, input bit br,
                       input bit tk, input logic [31:0] tg, input bit pt, input logic [31:0] pn);
    ex_valid_i = v; ex_epoch_i = EW'(ep); ex_pc_i = pc; ex_is_br_i = br;
    ex_taken_i = tk; ex_target_i = tg; pred_taken_i = pt; pred_npc_i = pn;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  // One clock: predict from current inputs, advance, compare all outputs.
  task automatic step();
    bit          rdy, xfer, cur, mp, trig;
    logic [31:0] npc, tgt;
    logic [31:0] exp_br, exp_mis;
    rdy  = (m_cyc >= m_ready_from);
    check("ready", 32'(ex_ready_o), 32'(rdy));
    xfer = ex_valid_i && rdy;
    cur  = (int'(ex_epoch_i) == m_epoch);
    npc  = (ex_is_br_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
    if (ex_is_br_i) mp = (ex_taken_i != pred_taken_i) || (ex_taken_i && ex_target_i != pred_npc_i);
    else            mp = pred_taken_i;
    mp   = mp && xfer && cur;
    trig = mp || exc_flush_i;
    tgt  = exc_flush_i ? exc_target_i : npc;
    if (xfer && cur && ex_is_br_i) m_br++;
    if (mp && !exc_flush_i) m_mis++;
    @(posedge clk);
    #1;
    m_cyc++;
    exc_flush_i = 1'b0;
    if (trig) begin
      m_epoch      = (m_epoch + 1) % (1 << EW);
      m_ready_from = m_cyc + HOLD;
      m_flush      = 1;
      m_tgt        = tgt[31:2];
    end else begin
      m_flush = 0;
    end
    check("flush", 32'(update_o.flush), 32'(m_flush));
    check("epoch", 32'(epoch_o), 32'(m_epoch));
    if (m_flush) check("br_target", 32'(update_o.br_target), 32'(m_tgt));
`ifdef BR_RESOLVE_PERF_EN
    exp_br = m_br; exp_mis = m_mis;
`else
    exp_br = 0; exp_mis = 0;
`endif
    check("br_cnt", br_cnt_o, exp_br);
    check("mispred_cnt", mispred_cnt_o, exp_mis);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < HOLD + 2 && m_cyc < m_ready_from; i++) step();
  endtask

  initial begin
    logic [31:0] pc, tg, pn;
    bit          tk;
    int          ep;
    m_cyc = 0;
    model_reset();
    idle();
    exc_flush_i = 0; exc_target_i = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush", 32'(update_o.flush), 32'd0);
    check("rst_target", 32'(update_o.br_target), 32'd0);
    check("rst_epoch", 32'(epoch_o), 32'd0);
    check("rst_ready", 32'(ex_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Idle after reset.
    repeat (5) step();

    // Correct taken prediction.
    drive(1, 0, 32'h1c000010, 1, 1, 32'h1c000100, 1, 32'h1c000100);
    step();
    idle();
    step();
    check("t2_epoch", 32'(epoch_o), 32'd0);

    // Direction miss.
    drive(1, 0, 32'h1c000010, 1, 0, 32'h1c000100, 1, 32'h1c000100);
    step();
    check("t3_target", 32'(update_o.br_target), 32'h07000005);
    check("t3_epoch", 32'(epoch_o), 32'd1);
    // Stale-epoch result offered while held and after.
    drive(1, 0, 32'h1c000020, 1, 0, 32'h1c000200, 1, 32'h1c000200);
    repeat (3) step();

    // Exception coincident with a mispredict.
    drive(1, 1, 32'h1c000010, 1, 0, 32'h1c000100, 1, 32'h1c000100);
    exc_flush_i = 1; exc_target_i = 32'h1c008000;
    step();
    check("t5_target", 32'(update_o.br_target), 32'h07002000);
    idle();
    wait_ready();

    // Bring epoch to 3, then mispredict to wrap, then exception during HOLD.
    exc_flush_i = 1; exc_target_i = 32'h1c00a004;
    step();
    wait_ready();
    check("t6_epoch3", 32'(epoch_o), 32'd3);
    drive(1, 3, 32'h1c000040, 0, 0, 32'h0, 1, 32'h1c001000);
    step();
    check("t6_wrap", 32'(epoch_o), 32'd0);
    idle();
    exc_flush_i = 1; exc_target_i = 32'h1c00c00b;
    step();
    check("t6_reflush", 32'(update_o.flush), 32'd1);
    repeat (HOLD + 1) step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      pc = $urandom & 32'hffff_fffc;
      tk = 1'($urandom);
      tg = $urandom;
      pn = ($urandom_range(0, 2) != 0) ? (tk ? tg : pc + 32'd4) : $urandom;
      ep = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : m_epoch;
      drive($urandom_range(0, 3) != 0, ep, pc, 1'($urandom), tk, tg, 1'($urandom), pn);
      exc_flush_i  = ($urandom_range(0, 15) == 0);
      exc_target_i = $urandom;
      step();
    end

    // Asynchronous reset in the middle of HOLD.
    drive(1, m_epoch, 32'h1c000010, 1, 0, 32'h1c000100, 1, 32'h1c000100);
    step();
    idle();
    rst_n = 0;
    #2;
    check("arst_flush", 32'(update_o.flush), 32'd0);
    check("arst_epoch", 32'(epoch_o), 32'd0);
    check("arst_ready", 32'(ex_ready_o), 32'd1);
    #1;
    rst_n = 1;
    model_reset();
    m_ready_from = 0;
    @(posedge clk);
    #1;
    m_cyc++;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
